fifo_reader: RTL and testbench

- Read-side controller for the team's single-clock FIFO (fifo_top + single-port RAM).
- Watches the FIFO empty flag, issues read_en strobes and captures the FIFO's registered read data.
- Re-presents that data on a valid/ready stream to the downstream consumer, in fixed-length bursts or in continuous mode.
- Never over-reads an empty FIFO; sustains one word per clock when downstream is ready.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_reader_if.sv | 26 ++
 rtl/fifo_skid_buf.sv | 74 +++++++
 rtl/fifo_reader.sv | 127 ++++++++++++
 tb/tb_fifo_reader.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side controller and its buffer.
// Holds the controller state encoding, the default data width and the FIFO read
// latency (cycles from read_en to valid fifo_out), which fifo_top also uses.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DATA_WIDTH_DEFAULT = 4;

  // fifo_out is registered: data appears one cycle after read_en. The reader's
  // single pending flag tracks exactly this one-cycle gap.
  localparam int unsigned READ_LATENCY = 1;

endpackage

// File: rtl/fifo_reader_if.sv
// Valid/ready stream carrying FIFO words to the downstream consumer.
//   m_data  : stream word, DATA_WIDTH+1 bits (same width as fifo_out)
//   m_valid : word on m_data is valid
//   m_ready : consumer accepts the word this cycle
// master drives data/valid, slave drives ready.
interface fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH_DEFAULT
) ();

  logic [DATA_WIDTH:0] m_data;
  logic                m_valid;
  logic                m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer between the FIFO read data and the stream.
//   clk         : clock, posedge
//   reset       : asynchronous active-low reset
//   push_i      : write push_data_i this cycle (caller guarantees count_o < 2 after any pop)
//   push_data_i : word to store
//   pop_i       : remove the head word (caller guarantees count_o > 0)
//   head_o      : oldest stored word
//   count_o     : number of stored words, 0..2
// A push into an empty buffer only becomes visible on head_o next cycle, so there
// is no combinational path from push_data_i to head_o.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [DATA_WIDTH:0] push_data_i,
  input  logic                pop_i,
  output logic [DATA_WIDTH:0] head_o,
  output logic [1:0]          count_o
);

  logic [DATA_WIDTH:0] head_q, head_d;
  logic [DATA_WIDTH:0] tail_q, tail_d;
  logic [1:0]          count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_data_i;
        end else begin
          tail_d = push_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Count unchanged; the incoming word lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the single-clock FIFO.
// Watches fifo_empty, issues read strobes, captures fifo_out one cycle later into
// a two-entry buffer and presents it as a valid/ready stream, either for a fixed
// burst of burst_len words or continuously (burst_len == 0) until stop.
//   clk          : clock, posedge
//   reset        : asynchronous active-low reset
//   fifo_empty   : FIFO empty flag (registered in the FIFO)
//   fifo_read_en : read strobe, one word per high cycle
//   fifo_out     : FIFO read data, valid the cycle after fifo_read_en
//   start        : begin a burst (accepted in IDLE only)
//   burst_len    : words to read, sampled on start; 0 = continuous
//   stop         : stop issuing reads and drain
//   busy         : controller in RUN or DRAIN
//   done         : one-cycle pulse when a burst has fully drained
//   word_count   : handshakes since the last accepted start
//   m_stream     : output stream (master)
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  output logic                 fifo_read_en,
  input  logic [DATA_WIDTH:0]  fifo_out,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] burst_len,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] word_count,
  fifo_reader_if.master        m_stream
);

  state_e               state_q;
  logic [LEN_WIDTH-1:0] remaining_q;
  logic                 continuous_q;
  logic                 pending_q;
  logic [LEN_WIDTH-1:0] word_count_q;

  logic [DATA_WIDTH:0]  buf_head;
  logic [1:0]           buf_count;
  logic                 m_valid;
  logic                 handshake;
  logic [2:0]           in_flight;
  logic                 read_ok;
  logic                 last_read;

  assign m_valid   = (buf_count != 2'd0);
  assign handshake = m_valid && m_stream.m_ready;

  // Words that will occupy the buffer after this edge: stored + arriving - leaving.
  // Issuing only while this is below 2 keeps the buffer from ever overflowing.
  assign in_flight = 3'(buf_count) + 3'(pending_q) - 3'(handshake);

  // fifo_empty is registered in the FIFO and updates on the same edge that samples
  // the strobe, so gating on the current flag is enough to never over-read and
  // still allows back-to-back reads.
  assign read_ok = (state_q == RUN) && !fifo_empty &&
                   (continuous_q || (remaining_q != '0)) &&
                   (in_flight < 3'd2);

  assign last_read = read_ok && !continuous_q && (remaining_q == LEN_WIDTH'(1));

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pending_q),
    .push_data_i (fifo_out),
    .pop_i       (handshake),
    .head_o      (buf_head),
    .count_o     (buf_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      continuous_q <= 1'b0;
      pending_q    <= 1'b0;
      word_count_q <= '0;
    end else begin
      pending_q <= read_ok;
      if (handshake) begin
        word_count_q <= word_count_q + LEN_WIDTH'(1);
      end
      case (state_q)
        IDLE: begin
          // stop is meaningless here, so start wins even if both are high.
          if (start) begin
            state_q      <= RUN;
            remaining_q  <= burst_len;
            continuous_q <= (burst_len == '0);
            word_count_q <= '0;
          end
        end
        RUN: begin
          if (read_ok && !continuous_q) begin
            remaining_q <= remaining_q - LEN_WIDTH'(1);
          end
          if (stop || last_read) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!pending_q && (buf_count == 2'd0)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_read_en    = read_ok;
  assign busy            = (state_q != IDLE);
  // Decoded from registered state only: high on the DRAIN -> IDLE cycle.
  assign done            = (state_q == DRAIN) && !pending_q && (buf_count == 2'd0);
  assign word_count      = word_count_q;
  assign m_stream.m_valid = m_valid;
  assign m_stream.m_data  = buf_head;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

  localparam int unsigned DW = 4;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_read_en;
  logic [DW:0]   fifo_out = '0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          stop = 1'b0;
  logic          busy;
  logic          done;
  logic [LW-1:0] word_count;

  fifo_reader_if #(.DATA_WIDTH(DW)) s_if ();

  fifo_reader #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_read_en (fifo_read_en),
    .fifo_out     (fifo_out),
    .start        (start),
    .burst_len    (burst_len),
    .stop         (stop),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .m_stream     (s_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered data and empty flag, both updated on the read edge.
  logic [DW:0] fifo_mem[$];
  logic [DW:0] exp_q[$];
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_read_en && fifo_mem.size() > 0) fifo_out <= fifo_mem.pop_front();
    fifo_empty <= (fifo_mem.size() == 0);
  end

  // Monitor: event logs by cycle, scoreboard compare on each handshake.
  int rd_q[$];
  int hs_q[$];
  int done_q[$];
  int overread_cnt = 0;

  always @(negedge clk) begin
    if (fifo_read_en) begin
      rd_q.push_back(cyc);
      if (fifo_empty) overread_cnt++;
    end
    if (done) done_q.push_back(cyc);
    if (s_if.m_valid && s_if.m_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) check("sb_unexpected_word", 32'(s_if.m_data), 32'hffff_ffff);
      else check("sb_data", 32'(s_if.m_data), 32'(exp_q.pop_front()));
    end
  end

  int rd_base, hs_base, done_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n, input int deliver);
    for (int i = 0; i < n; i++) begin
      fifo_mem.push_back(5'(base + i));
      if (i < deliver) exp_q.push_back(5'(base + i));
    end
    tick();
    tick();
  endtask

  task automatic flush();
    fifo_mem.delete();
    tick();
    tick();
  endtask

  task automatic start_burst(input int len, input logic with_stop);
    rd_base   = rd_q.size();
    hs_base   = hs_q.size();
    done_base = done_q.size();
    burst_len = LW'(len);
    start     = 1'b1;
    stop      = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_q.size() == done_base && n < 300) begin
      tick();
      n++;
    end
    if (done_q.size() == done_base) check({tag, "_done_timeout"}, 0, 1);
    tick();
  endtask

  // Common end-of-burst checks: counts, done one cycle after last handshake.
  task automatic end_burst(input string tag, input int words);
    check({tag, "_reads"}, 32'(rd_q.size() - rd_base), 32'(words));
    check({tag, "_handshakes"}, 32'(hs_q.size() - hs_base), 32'(words));
    check({tag, "_done_pulses"}, 32'(done_q.size() - done_base), 1);
    if (done_q.size() > done_base && hs_q.size() > hs_base)
      check({tag, "_done_lag"}, 32'(done_q[done_q.size()-1] - hs_q[hs_q.size()-1]), 1);
    check({tag, "_word_count"}, 32'(word_count), 32'(words));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int gaps;
    int n;
    int stable_err;
    logic [DW:0] held;
    logic valid_in_stall;

    s_if.m_ready = 1'b1;
    #23;
    check("rst_read_en", 32'(fifo_read_en), 0);
    check("rst_m_valid", 32'(s_if.m_valid), 0);
    check("rst_m_data", 32'(s_if.m_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_word_count", 32'(word_count), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fixed burst, free flow.
    load(1, 8, 8);
    start_burst(8, 1'b0);
    check("t1_first_read_latency", 32'(fifo_read_en), 1);
    wait_done("t1");
    end_burst("t1", 8);
    if (rd_q.size() >= rd_base + 8)
      check("t1_read_span", 32'(rd_q[rd_base+7] - rd_q[rd_base]), 7);
    if (hs_q.size() >= hs_base + 8) begin
      check("t1_hs_span", 32'(hs_q[hs_base+7] - hs_q[hs_base]), 7);
      check("t1_read_to_valid", 32'(hs_q[hs_base] - rd_q[rd_base]), 2);
    end

    // Empty stall: two words now, the rest 10 cycles later.
    load(10, 2, 2);
    start_burst(4, 1'b0);
    repeat (10) tick();
    check("t2_stall_reads", 32'(rd_q.size() - rd_base), 2);
    check("t2_no_early_done", 32'(done_q.size() - done_base), 0);
    check("t2_busy_in_stall", 32'(busy), 1);
    for (int i = 0; i < 2; i++) begin
      fifo_mem.push_back(5'(12 + i));
      exp_q.push_back(5'(12 + i));
    end
    wait_done("t2");
    end_burst("t2", 4);

    // Backpressure mid-burst.
    load(24, 8, 8);
    start_burst(8, 1'b0);
    n = 0;
    while (hs_q.size() - hs_base < 2 && n < 50) begin
      tick();
      n++;
    end
    s_if.m_ready = 1'b0;
    stable_err = 0;
    valid_in_stall = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        held = s_if.m_data;
        valid_in_stall = s_if.m_valid;
      end else if (s_if.m_data !== held || !s_if.m_valid) begin
        stable_err++;
      end
    end
    check("t3_outstanding", 32'((rd_q.size() - rd_base) - (hs_q.size() - hs_base)), 2);
    check("t3_valid_in_stall", 32'(valid_in_stall), 1);
    check("t3_data_stable", 32'(stable_err), 0);
    tick();
    s_if.m_ready = 1'b1;
    wait_done("t3");
    end_burst("t3", 8);
    gaps = 0;
    for (int i = hs_base + 1; i < hs_q.size(); i++)
      if (hs_q[i] != hs_q[i-1] + 1) gaps++;
    check("t3_single_gap", 32'(gaps), 1);

    // Continuous mode, stop on the cycle of the 6th read.
    load(16, 16, 6);
    start_burst(0, 1'b0);
    repeat (5) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("t4");
    repeat (5) tick();
    end_burst("t4", 6);
    flush();

    // Single-word burst.
    load(3, 2, 1);
    start_burst(1, 1'b0);
    wait_done("t5");
    end_burst("t5", 1);
    flush();

    // Start while busy is ignored.
    load(12, 4, 4);
    start_burst(4, 1'b0);
    burst_len = LW'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6");
    end_burst("t6", 4);

    // start and stop together in IDLE: burst runs normally.
    load(21, 3, 3);
    start_burst(3, 1'b1);
    wait_done("t7");
    end_burst("t7", 3);

    // Asynchronous reset with one word buffered and one read in flight.
    load(29, 4, 0);
    s_if.m_ready = 1'b0;
    start_burst(4, 1'b0);
    tick();
    tick();
    check("t8_pre_valid", 32'(s_if.m_valid), 1);
    check("t8_pre_data", 32'(s_if.m_data), 29);
    #2;
    reset = 1'b0;
    #1;
    check("t8_read_en", 32'(fifo_read_en), 0);
    check("t8_m_valid", 32'(s_if.m_valid), 0);
    check("t8_m_data", 32'(s_if.m_data), 0);
    check("t8_busy", 32'(busy), 0);
    check("t8_done", 32'(done), 0);
    fifo_mem.delete();
    repeat (3) tick();
    check("t8_no_done_pulse", 32'(done_q.size() - done_base), 0);
    @(negedge clk);
    reset = 1'b1;
    s_if.m_ready = 1'b1;
    tick();
    load(6, 2, 2);
    start_burst(2, 1'b0);
    wait_done("t8_after");
    end_burst("t8_after", 2);

    check("no_overread", 32'(overread_cnt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
